bmem_arbiter: RTL

Two-client arbiter that sits directly downstream of the instruction-cache and data-cache line adapters and shares the single burst memory port (bmem) between them. Each adapter speaks the native bmem protocol: 64-bit beats, BURST_LEN beats per cache line. The arbiter grants the port to exactly one client per transaction and holds that grant until the full burst completes. Grants are round-robin, and read-return beats are routed back to the owning client.

---
 rtl/bmem_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/bmem_arbiter.sv
// Two-client round-robin arbiter sharing one burst memory port between the
// icache (read-only) and dcache line adapters; grant held for a full burst.
module bmem_arbiter #(
  parameter int unsigned BURST_LEN = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_addr,
  input  logic        i_read,
  output logic        i_ready,
  output logic        i_rvalid,
  output logic [63:0] i_rdata,
  input  logic [31:0] d_addr,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [63:0] d_wdata,
  output logic        d_ready,
  output logic        d_rvalid,
  output logic [63:0] d_rdata,
  output logic [31:0] bmem_addr,
  output logic        bmem_read,
  output logic        bmem_write,
  output logic [63:0] bmem_wdata,
  input  logic        bmem_ready,
  input  logic        bmem_rvalid,
  input  logic [63:0] bmem_rdata
);

  localparam int unsigned CW = $clog2(BURST_LEN) + 1;
  localparam logic [CW-1:0] LAST = CW'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, RD_I, RD_D, WR_D} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic          prio_q, prio_d;
  logic          pend_i, pend_d, grant_i, grant_d;

  assign i_rdata = bmem_rdata;
  assign d_rdata = bmem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      prio_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      prio_q  <= prio_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    prio_d     = prio_q;
    i_ready    = 1'b0;
    d_ready    = 1'b0;
    i_rvalid   = 1'b0;
    d_rvalid   = 1'b0;
    bmem_addr  = '0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_wdata = '0;

    pend_i  = i_read;
    pend_d  = d_read | d_write;
    // prio=0 favours dcache, prio=1 favours icache
    grant_d = pend_d & (~pend_i | ~prio_q);
    grant_i = pend_i & ~grant_d;

    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          bmem_addr  = d_addr;
          bmem_read  = d_read;
          bmem_write = d_write;
          bmem_wdata = d_wdata;
          d_ready    = bmem_ready;
          if (d_read && bmem_ready) begin
            addr_d  = d_addr;
            cnt_d   = '0;
            prio_d  = 1'b1;
            state_d = RD_D;
          end else if (d_write && bmem_ready) begin
            addr_d = d_addr;
            cnt_d  = CW'(1);
            prio_d = 1'b1;
            if (BURST_LEN > 1) state_d = WR_D;
          end
        end else if (grant_i) begin
          bmem_addr = i_addr;
          bmem_read = 1'b1;
          i_ready   = bmem_ready;
          if (bmem_ready) begin
            addr_d  = i_addr;
            cnt_d   = '0;
            prio_d  = 1'b0;
            state_d = RD_I;
          end
        end
      end
      RD_I: begin
        i_rvalid = bmem_rvalid;
        if (bmem_rvalid) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = IDLE;
        end
      end
      RD_D: begin
        d_rvalid = bmem_rvalid;
        if (bmem_rvalid) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = IDLE;
        end
      end
      WR_D: begin
        bmem_addr  = addr_q;
        bmem_write = d_write;
        bmem_wdata = d_wdata;
        d_ready    = bmem_ready;
        if (d_write && bmem_ready) begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == LAST) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // All handshake and memory outputs are forced quiet while in reset
    if (rst) begin
      i_ready    = 1'b0;
      d_ready    = 1'b0;
      i_rvalid   = 1'b0;
      d_rvalid   = 1'b0;
      bmem_addr  = '0;
      bmem_read  = 1'b0;
      bmem_write = 1'b0;
      bmem_wdata = '0;
    end
  end

endmodule
